// File: rtl/rx_uart.sv
// UART receiver: 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit, no parity.
// Bit timing comes from an external oversampling tick (TICKS ticks per bit period).
module rx_uart #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned TICKS     = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_s_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done_tick,
  output logic                 o_frame_error
);

  localparam int unsigned TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(TICKS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [TW-1:0]          tick_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [DATA_BITS-1:0]   shreg_d;
  logic [DATA_BITS-1:0]   data_q;
  logic                   done_q;
  logic                   ferr_q;

  // Two-flop synchronizer for the asynchronous RX pin; idles high.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_rx};
    end
  end

  assign rx_s = sync_q[1];

  // Next shift-register value: the sampled bit enters at the MSB so the LSB ends up first-received.
  always_comb begin
    shreg_d                = shreg_q >> 1;
    shreg_d[DATA_BITS-1]   = rx_s;
  end

  // Receive FSM: start detect on any clock, everything else advances only on ticks.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            tick_q  <= '0;
          end
        end

        START: begin
          if (i_s_tick) begin
            if (tick_q == HALF_LAST) begin
              // Mid start bit: a still-low line confirms a real start, otherwise it was a glitch.
              if (!rx_s) begin
                state_q <= DATA;
                tick_q  <= '0;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end

        DATA: begin
          if (i_s_tick) begin
            if (tick_q == FULL_LAST) begin
              shreg_q <= shreg_d;
              tick_q  <= '0;
              if (bit_q == BIT_LAST) begin
                state_q <= STOP;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end

        STOP: begin
          if (i_s_tick) begin
            if (tick_q == FULL_LAST) begin
              // Mid stop bit: deliver the word and return to IDLE so a back-to-back start is caught.
              data_q  <= shreg_q;
              ferr_q  <= ~rx_s;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_data         = data_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_error  = ferr_q;

endmodule
